apb_timer_periph: RTL and testbench

APB3 responder peripheral implementing a 32-bit up-counting timer with 16-bit prescaler, auto-reload, one-shot mode and a level interrupt. Sits on the MCU APB bus alongside the RAM, GPO, GPI and UART responders. It is selected by one of the APB master's PSEL lines and returns PRDATA/PREADY to the master's read mux. It inserts exactly one wait state per transfer.

---
 rtl/apb_timer_pkg.sv | 36 +++
 rtl/apb_timer_periph_core.sv | 47 ++++
 rtl/apb_timer_periph.sv | 166 ++++++++++++++++
 tb/tb_apb_timer_periph.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
`default_nettype none
// ==================================================================
// apb_timer_pkg : register map, TCR fields and reset constants
// Rev 1.0
// ==================================================================
package apb_timer_pkg;

    localparam logic [2:0] REG_TCR  = 3'd0;
    localparam logic [2:0] REG_PSC  = 3'd1;
    localparam logic [2:0] REG_ARR  = 3'd2;
    localparam logic [2:0] REG_TCNT = 3'd3;
    localparam logic [2:0] REG_TSR  = 3'd4;

    localparam int TCR_EN  = 0;
    localparam int TCR_CLR = 1;
    localparam int TCR_OPM = 2;
    localparam int TCR_IE  = 3;

    localparam logic [31:0] RESET_VAL = 32'h0000_0000;

    // APB responder states; bit 1 doubles as the registered PREADY
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic [31:0] pack_tcr(input logic en, input logic opm, input logic ie);
        logic [31:0] v;
        v           = RESET_VAL;
        v[TCR_EN]   = en;
        v[TCR_OPM]  = opm;
        v[TCR_IE]   = ie;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_timer_periph_core.sv
`default_nettype none
// ==================================================================
// timer_core : prescaler, 32-bit up-counter and reload compare
// Rev 1.0
// ==================================================================
module timer_core
    import apb_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        opm,
    input  logic [15:0] psc,
    input  logic [31:0] arr,
    output logic [31:0] tcnt,
    output logic        reload,
    output logic        opm_stop
);

    logic [15:0] psc_cnt;
    logic        tick;
    logic        at_top;

    assign tick     = en & (psc_cnt == psc);
    // >= lets a lowered ARR force a reload instead of running to 2^32
    assign at_top   = (tcnt >= arr);
    assign reload   = tick & at_top & ~clr;
    assign opm_stop = reload & opm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt <= RESET_VAL[15:0];
            tcnt    <= RESET_VAL;
        end else if (clr) begin
            psc_cnt <= 16'd0;
            tcnt    <= 32'd0;
        end else if (en) begin
            psc_cnt <= tick ? 16'd0 : psc_cnt + 16'd1;
            if (tick) begin
                tcnt <= at_top ? 32'd0 : tcnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_timer_periph.sv
`default_nettype none
// ==================================================================
// apb_timer_periph : APB3 responder for a prescaled auto-reload timer
// Rev 1.0
// ==================================================================
module apb_timer_periph #(
    parameter int ADDR_W = 5
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic [31:0]       PWDATA,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              irq,
    output logic              tick_out
);
    import apb_timer_pkg::*;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        xfer_acc;
    logic        wr_q;
    logic [2:0]  idx_q;
    logic [31:0] wdata_q;

    logic        en;
    logic        opm;
    logic        ie;
    logic        uif;
    logic [15:0] psc;
    logic [31:0] arr;
    logic [31:0] tcnt;

    logic        commit;
    logic        wr_tcr;
    logic        wr_psc;
    logic        wr_arr;
    logic        wr_tsr;
    logic        clr;
    logic        reload;
    logic        opm_stop;
    logic [31:0] rd_mux;
    logic        unused_addr_lo;

    assign xfer_acc = PSEL & PENABLE & ~PREADY;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (xfer_acc) begin
            state_d = ST_DONE;
        end else if (PSEL & ~PENABLE) begin
            state_d = ST_WAIT;
        end
    end

    always_comb begin
        PREADY = state_q[1];
    end

    // Transfer attributes are latched so the commit does not depend on the
    // master holding the bus through the PREADY cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_q    <= 1'b0;
            idx_q   <= 3'd0;
            wdata_q <= RESET_VAL;
            PRDATA  <= RESET_VAL;
        end else if (xfer_acc) begin
            wr_q    <= PWRITE;
            idx_q   <= PADDR[4:2];
            wdata_q <= PWDATA;
            if (!PWRITE) begin
                PRDATA <= rd_mux;
            end
        end
    end

    assign commit = PREADY & wr_q;
    assign wr_tcr = commit & (idx_q == REG_TCR);
    assign wr_psc = commit & (idx_q == REG_PSC);
    assign wr_arr = commit & (idx_q == REG_ARR);
    assign wr_tsr = commit & (idx_q == REG_TSR);
    assign clr    = wr_tcr & wdata_q[TCR_CLR];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en  <= 1'b0;
            opm <= 1'b0;
            ie  <= 1'b0;
            uif <= 1'b0;
            psc <= RESET_VAL[15:0];
            arr <= RESET_VAL;
        end else begin
            if (wr_tcr) begin
                en  <= wdata_q[TCR_EN];
                opm <= wdata_q[TCR_OPM];
                ie  <= wdata_q[TCR_IE];
            end else if (opm_stop) begin
                en  <= 1'b0;
            end
            if (wr_psc) begin
                psc <= wdata_q[15:0];
            end
            if (wr_arr) begin
                arr <= wdata_q;
            end
            // a hardware set in the same cycle beats the software clear
            if (reload) begin
                uif <= 1'b1;
            end else if (wr_tsr & wdata_q[0]) begin
                uif <= 1'b0;
            end
        end
    end

    timer_core u_core (
        .clk      (PCLK),
        .rst      (PRESET),
        .en       (en),
        .clr      (clr),
        .opm      (opm),
        .psc      (psc),
        .arr      (arr),
        .tcnt     (tcnt),
        .reload   (reload),
        .opm_stop (opm_stop)
    );

    always_comb begin
        rd_mux = RESET_VAL;
        case (PADDR[4:2])
            REG_TCR:  rd_mux = pack_tcr(en, opm, ie);
            REG_PSC:  rd_mux = {16'd0, psc};
            REG_ARR:  rd_mux = arr;
            REG_TCNT: rd_mux = tcnt;
            REG_TSR:  rd_mux = {31'd0, uif};
            default:  rd_mux = RESET_VAL;
        endcase
    end

    assign irq      = uif & ie;
    assign tick_out = reload;

    assign unused_addr_lo = ^PADDR[1:0];

    generate
        if (ADDR_W > 5) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^PADDR[ADDR_W-1:5];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_periph.sv
`default_nettype none
// ==================================================================
// tb_apb_timer_periph : directed + random bench with a timer model
// Rev 1.0
// ==================================================================
module tb_apb_timer_periph;

    logic        PCLK;
    logic        PRESET;
    logic [4:0]  PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;
    logic        tick_out;

    apb_timer_periph #(.ADDR_W(5)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .irq      (irq),
        .tick_out (tick_out)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_ticks  = 0;
    int tick_prev = 0;
    int tick_last = 0;

    // behavioural state of the timer as seen by software
    bit          m_en, m_opm, m_ie, m_uif;
    logic [15:0] m_psc, m_pscc;
    logic [31:0] m_arr, m_tcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_opm = 0; m_ie = 0; m_uif = 0;
        m_psc = 0; m_pscc = 0; m_arr = 0; m_tcnt = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] i);
        case (i)
            3'd0:    return {28'h0, m_ie, m_opm, 1'b0, m_en};
            3'd1:    return {16'h0, m_psc};
            3'd2:    return m_arr;
            3'd3:    return m_tcnt;
            3'd4:    return {31'h0, m_uif};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: check this cycle's outputs, then advance the model across
    // the edge, applying a write that commits on it.
    task automatic cycle(input bit cv, input logic [2:0] ci, input logic [31:0] cd);
        bit          wtcr, clr, tick, rel;
        bit          n_en, n_uif;
        logic [15:0] n_pscc;
        logic [31:0] n_tcnt;
        wtcr = cv && (ci == 3'd0);
        clr  = wtcr && cd[1];
        tick = m_en && (m_pscc == m_psc);
        rel  = tick && (m_tcnt >= m_arr) && !clr;
        chk("tick_out", 32'(tick_out), 32'(rel));
        chk("irq", 32'(irq), 32'(m_uif & m_ie));
        if (tick_out === 1'b1) begin
            tick_prev = tick_last;
            tick_last = cyc;
            n_ticks++;
        end
        n_pscc = m_pscc;
        n_tcnt = m_tcnt;
        if (clr) begin
            n_pscc = 0;
            n_tcnt = 0;
        end else if (m_en) begin
            n_pscc = tick ? 16'd0 : m_pscc + 16'd1;
            if (tick) n_tcnt = rel ? 32'd0 : m_tcnt + 32'd1;
        end
        n_uif = rel ? 1'b1 : ((cv && ci == 3'd4 && cd[0]) ? 1'b0 : m_uif);
        n_en  = wtcr ? cd[0] : ((rel && m_opm) ? 1'b0 : m_en);
        @(posedge PCLK);
        #1;
        cyc++;
        m_pscc = n_pscc; m_tcnt = n_tcnt; m_uif = n_uif; m_en = n_en;
        if (wtcr) begin
            m_opm = cd[2];
            m_ie  = cd[3];
        end
        if (cv && ci == 3'd1) m_psc = cd[15:0];
        if (cv && ci == 3'd2) m_arr = cd;
    endtask

    task automatic apb(input bit wr, input logic [4:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata);
        logic [31:0] exp;
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data;
        cycle(0, 3'd0, 32'h0);
        chk("pready_t1", 32'(PREADY), 32'h0);
        PENABLE = 1;
        exp = model_read(addr[4:2]);
        cycle(0, 3'd0, 32'h0);
        chk("pready_t2", 32'(PREADY), 32'h1);
        if (!wr) chk("prdata", PRDATA, exp);
        rdata = PRDATA;
        cycle(wr, addr[4:2], data);
        chk("pready_t3", 32'(PREADY), 32'h0);
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        apb(1'b1, addr, data, dummy);
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] data);
        apb(1'b0, addr, 32'h0, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 32'h0);
    endtask

    task automatic idle_until_tcnt(input logic [31:0] v);
        for (int i = 0; i < 300 && m_tcnt != v; i++) cycle(0, 3'd0, 32'h0);
        if (m_tcnt != v) chk("wait_tcnt_timeout", m_tcnt, v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, d;
        int          n0, op;
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        model_reset();
        #1;
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", 32'(PREADY), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_tick", 32'(tick_out), 32'h0);
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 0;
        for (int i = 0; i < 5; i++) begin
            rd(5'(i << 2), r);
            chk("rst_reg", r, 32'h0);
        end

        // handshake and decode
        wr(5'h08, 32'h5);
        rd(5'h08, r);
        chk("arr_read", r, 32'h5);
        rd(5'h14, r);
        chk("unmapped_read", r, 32'h0);

        // prescaled auto-reload: period (PSC+1)*(ARR+1)
        wr(5'h04, 32'h2);
        wr(5'h08, 32'h3);
        wr(5'h00, 32'h9);
        n0 = n_ticks;
        for (int i = 0; i < 100 && n_ticks < n0 + 2; i++) cycle(0, 3'd0, 32'h0);
        if (n_ticks < n0 + 2) chk("tick_wait_timeout", 32'(n_ticks), 32'(n0 + 2));
        chk("tick_period", 32'(tick_last - tick_prev), 32'd12);
        chk("irq_after_reload", 32'(irq), 32'h1);
        rd(5'h10, r);
        chk("tsr_set", r, 32'h1);
        wr(5'h10, 32'h1);
        chk("irq_cleared", 32'(irq), 32'h0);

        // reset in the middle of a write transfer while counting
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 5'h08; PWDATA = 32'h77;
        cycle(0, 3'd0, 32'h0);
        PENABLE = 1;
        cycle(0, 3'd0, 32'h0);
        chk("pready_pre_rst", 32'(PREADY), 32'h1);
        #2 PRESET = 1;
        #1;
        chk("midrst_pready", 32'(PREADY), 32'h0);
        chk("midrst_prdata", PRDATA, 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_tick", 32'(tick_out), 32'h0);
        PSEL = 0; PENABLE = 0;
        @(posedge PCLK);
        #1;
        PRESET = 0;
        model_reset();
        rd(5'h0C, r);
        chk("midrst_tcnt", r, 32'h0);
        rd(5'h08, r);
        chk("midrst_no_commit", r, 32'h0);

        // one-shot
        wr(5'h08, 32'h2);
        n0 = n_ticks;
        wr(5'h00, 32'h7);
        idle(6);
        chk("opm_single_reload", 32'(n_ticks - n0), 32'h1);
        rd(5'h00, r);
        chk("opm_en_cleared", r, 32'h4);
        rd(5'h0C, r);
        chk("opm_tcnt_zero", r, 32'h0);

        // CLR committing on a reload-tick edge
        wr(5'h08, 32'h8);
        wr(5'h00, 32'h3);
        wr(5'h10, 32'h1);
        idle_until_tcnt(32'd6);
        n0 = n_ticks;
        wr(5'h00, 32'h3);
        chk("clr_blocks_tick", 32'(n_ticks - n0), 32'h0);
        rd(5'h10, r);
        chk("clr_no_uif", r, 32'h0);

        // W1C committing on a reload edge
        idle_until_tcnt(32'd6);
        wr(5'h10, 32'h1);
        rd(5'h10, r);
        chk("uif_set_wins", r, 32'h1);

        // ARR lowered below TCNT
        wr(5'h08, 32'd100);
        wr(5'h00, 32'h3);
        wr(5'h10, 32'h1);
        idle_until_tcnt(32'd8);
        wr(5'h08, 32'h4);
        rd(5'h10, r);
        chk("arr_lowered_uif", r, 32'h1);

        // random traffic against the model
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: begin
                    d = 32'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                    wr(5'h00, d);
                end
                1: begin
                    d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                    wr(5'h04, d);
                    wr(5'h00, 32'h3 | (32'($urandom_range(0, 1)) << 3));
                end
                2: wr(5'h08, 32'($urandom_range(0, 15)));
                3: wr(5'h10, $urandom);
                4, 5, 6: rd(5'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3)), r);
                7: wr(5'($urandom_range(5, 7) << 2), $urandom);
                8: idle($urandom_range(1, 8));
                default: begin
                    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 5'h08; PWDATA = $urandom;
                    cycle(0, 3'd0, 32'h0);
                    PSEL = 0;
                    cycle(0, 3'd0, 32'h0);
                    chk("abandoned_pready", 32'(PREADY), 32'h0);
                end
            endcase
        end
        for (int i = 0; i < 5; i++) rd(5'(i << 2), r);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
